// File: rtl/score_overlay.sv
// Two-digit scoreboard: goal counting, per-frame display latch, font ROM addressing.
// Optional digit flashing after a goal when SCORE_FLASH_EN is defined.
module score_overlay #(
  parameter int X0           = 288,
  parameter int Y0           = 16,
  parameter int SCALE_LOG2   = 2,
  parameter int GAP          = 32,
  parameter int WIN_SCORE    = 9,
  parameter int FLASH_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       goal_left,
  input  logic       goal_right,
  input  logic       score_clr,
  input  logic       frame_start,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  output logic [3:0] rom_char,
  output logic [2:0] rom_row,
  input  logic [7:0] rom_pixels,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       game_over,
  output logic       pix_on,
  output logic       video_on_d
);

  localparam int S  = 1 << SCALE_LOG2;
  localparam int DW = 8 * S;
  localparam int XR = X0 + DW + GAP;

  localparam logic [3:0]        WIN   = 4'(WIN_SCORE);
  localparam logic signed [10:0] X0_S = 11'(X0);
  localparam logic signed [10:0] XR_S = 11'(XR);
  localparam logic signed [10:0] Y0_S = 11'(Y0);
  localparam logic signed [10:0] DW_S = 11'(DW);

  // An out-of-range configuration blanks the digits rather than mis-rendering.
  localparam bit CFG_OK = (WIN_SCORE >= 1) && (WIN_SCORE <= 9) &&
                          (FLASH_FRAMES >= 0) && (FLASH_FRAMES < 64);

  logic       w_acc_l;
  logic       w_acc_r;
  logic [3:0] r_disp_l;
  logic [3:0] r_disp_r;

  assign game_over = (score_left == WIN) | (score_right == WIN);
  assign w_acc_l   = goal_left  & ~game_over & ~score_clr;
  assign w_acc_r   = goal_right & ~game_over & ~score_clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score_left  <= '0;
      score_right <= '0;
    end else if (score_clr) begin
      score_left  <= '0;
      score_right <= '0;
    end else begin
      if (w_acc_l) score_left  <= score_left + 4'd1;
      if (w_acc_r) score_right <= score_right + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_l <= '0;
      r_disp_r <= '0;
    end else if (frame_start) begin
      r_disp_l <= score_left;
      r_disp_r <= score_right;
    end
  end

  logic signed [10:0] w_dxl;
  logic signed [10:0] w_dxr;
  logic signed [10:0] w_dy;
  logic               w_iny;
  logic               w_inl;
  logic               w_inr;
  logic [2:0]         w_col;

  assign w_dxl = $signed({1'b0, hcount}) - X0_S;
  assign w_dxr = $signed({1'b0, hcount}) - XR_S;
  assign w_dy  = $signed({1'b0, vcount}) - Y0_S;

  assign w_iny = ~w_dy[10]  & (w_dy  < DW_S);
  assign w_inl = ~w_dxl[10] & (w_dxl < DW_S) & w_iny;
  assign w_inr = ~w_dxr[10] & (w_dxr < DW_S) & w_iny;

  assign w_col = w_inr ? w_dxr[SCALE_LOG2+2 -: 3]
                       : w_dxl[SCALE_LOG2+2 -: 3];

  logic       r_hit1;
  logic       r_side1;
  logic [2:0] r_col1;
  logic       r_von1;
  logic       w_blank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit1   <= 1'b0;
      r_side1  <= 1'b0;
      r_col1   <= '0;
      rom_char <= '0;
      rom_row  <= '0;
    end else if (video_on && (w_inl || w_inr)) begin
      r_hit1   <= 1'b1;
      r_side1  <= w_inr;
      r_col1   <= w_col;
      rom_char <= w_inr ? r_disp_r : r_disp_l;
      rom_row  <= w_dy[SCALE_LOG2+2 -: 3];
    end else begin
      r_hit1   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_von1     <= 1'b0;
      video_on_d <= 1'b0;
      pix_on     <= 1'b0;
    end else begin
      r_von1     <= video_on;
      video_on_d <= r_von1;
      pix_on     <= r_hit1 & rom_pixels[3'd7 - r_col1] & ~w_blank;
    end
  end

`ifdef SCORE_FLASH_EN
  localparam logic [5:0] FL_LD = 6'(FLASH_FRAMES);

  logic [5:0] r_fl_l;
  logic [5:0] r_fl_r;
  logic       w_fl_l;
  logic       w_fl_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fl_l <= '0;
      r_fl_r <= '0;
    end else if (score_clr) begin
      r_fl_l <= '0;
      r_fl_r <= '0;
    end else begin
      if (w_acc_l)
        r_fl_l <= FL_LD;
      else if (frame_start && r_fl_l != 6'd0)
        r_fl_l <= r_fl_l - 6'd1;
      if (w_acc_r)
        r_fl_r <= FL_LD;
      else if (frame_start && r_fl_r != 6'd0)
        r_fl_r <= r_fl_r - 6'd1;
    end
  end

  assign w_fl_l  = (r_fl_l != 6'd0) & r_fl_l[3];
  assign w_fl_r  = (r_fl_r != 6'd0) & r_fl_r[3];
  assign w_blank = ~CFG_OK | (r_side1 ? w_fl_r : w_fl_l);
`else
  assign w_blank = ~CFG_OK;
`endif

endmodule

// File: tb/tb_score_overlay.sv
// Directed bench for score_overlay: vector table plus scoring/reset sequences.
module tb_score_overlay;

  logic       clk;
  logic       rst_n;
  logic       goal_left;
  logic       goal_right;
  logic       score_clr;
  logic       frame_start;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       video_on;
  logic [3:0] rom_char;
  logic [2:0] rom_row;
  logic [7:0] rom_pixels;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       game_over;
  logic       pix_on;
  logic       video_on_d;

  int n_chk = 0;
  int n_err = 0;

  score_overlay dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .goal_left  (goal_left),
    .goal_right (goal_right),
    .score_clr  (score_clr),
    .frame_start(frame_start),
    .hcount     (hcount),
    .vcount     (vcount),
    .video_on   (video_on),
    .rom_char   (rom_char),
    .rom_row    (rom_row),
    .rom_pixels (rom_pixels),
    .score_left (score_left),
    .score_right(score_right),
    .game_over  (game_over),
    .pix_on     (pix_on),
    .video_on_d (video_on_d)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [9:0] h;
    logic [9:0] v;
    logic       von;
    logic [7:0] px;
    logic [3:0] ch;
    logic [2:0] row;
    logic       pix;
  } vec_t;

  vec_t vt[18];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic pulse(input logic l, input logic r, input logic c,
                       input logic f);
    goal_left   = l;
    goal_right  = r;
    score_clr   = c;
    frame_start = f;
    tick();
    goal_left   = 1'b0;
    goal_right  = 1'b0;
    score_clr   = 1'b0;
    frame_start = 1'b0;
  endtask

  task automatic pix_at(input logic [9:0] h, input logic [9:0] v);
    hcount   = h;
    vcount   = v;
    video_on = 1'b1;
    tick();
    tick();
  endtask

  logic pat[6];
  int   cnt;

  initial begin
    vt[0]  = '{10'd300,  10'd16,   1'b1, 8'h18, 4'd1, 3'd0, 1'b1};
    vt[1]  = '{10'd287,  10'd16,   1'b1, 8'hFF, 4'd1, 3'd0, 1'b0};
    vt[2]  = '{10'd288,  10'd16,   1'b1, 8'h80, 4'd1, 3'd0, 1'b1};
    vt[3]  = '{10'd319,  10'd47,   1'b1, 8'h01, 4'd1, 3'd7, 1'b1};
    vt[4]  = '{10'd320,  10'd47,   1'b1, 8'hFF, 4'd1, 3'd7, 1'b0};
    vt[5]  = '{10'd352,  10'd20,   1'b1, 8'h80, 4'd2, 3'd1, 1'b1};
    vt[6]  = '{10'd383,  10'd30,   1'b1, 8'h02, 4'd2, 3'd3, 1'b0};
    vt[7]  = '{10'd383,  10'd30,   1'b1, 8'h01, 4'd2, 3'd3, 1'b1};
    vt[8]  = '{10'd300,  10'd48,   1'b1, 8'hFF, 4'd2, 3'd3, 1'b0};
    vt[9]  = '{10'd300,  10'd15,   1'b1, 8'hFF, 4'd2, 3'd3, 1'b0};
    vt[10] = '{10'd300,  10'd20,   1'b0, 8'hFF, 4'd2, 3'd3, 1'b0};
    vt[11] = '{10'd351,  10'd20,   1'b1, 8'hFF, 4'd2, 3'd3, 1'b0};
    vt[12] = '{10'd0,    10'd0,    1'b1, 8'hFF, 4'd2, 3'd3, 1'b0};
    vt[13] = '{10'd1023, 10'd1023, 1'b1, 8'hFF, 4'd2, 3'd3, 1'b0};
    vt[14] = '{10'd340,  10'd20,   1'b1, 8'hFF, 4'd2, 3'd3, 1'b0};
    vt[15] = '{10'd305,  10'd33,   1'b1, 8'h08, 4'd1, 3'd4, 1'b1};
    vt[16] = '{10'd305,  10'd33,   1'b1, 8'hF7, 4'd1, 3'd4, 1'b0};
    vt[17] = '{10'd384,  10'd47,   1'b1, 8'hFF, 4'd1, 3'd4, 1'b0};

    rst_n       = 1'b0;
    goal_left   = 1'b0;
    goal_right  = 1'b0;
    score_clr   = 1'b0;
    frame_start = 1'b0;
    hcount      = '0;
    vcount      = '0;
    video_on    = 1'b0;
    rom_pixels  = 8'hFF;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst score_left", score_left, 0);
    chk("rst score_right", score_right, 0);
    chk("rst game_over", game_over, 0);
    chk("rst pix_on", pix_on, 0);
    chk("rst rom_char", rom_char, 0);
    chk("rst rom_row", rom_row, 0);
    chk("rst video_on_d", video_on_d, 0);

    pulse(1, 0, 0, 0);
    chk("goal_left score", score_left, 1);
    pix_at(10'd300, 10'd16);
    chk("char before frame", rom_char, 0);
    pulse(0, 0, 0, 1);
    tick();
    chk("char after frame", rom_char, 1);
    pulse(0, 1, 0, 0);
    pulse(0, 1, 0, 0);
    chk("right score 2", score_right, 2);
    pulse(0, 0, 0, 1);
    video_on = 1'b0;
    tick();

    foreach (vt[i]) begin
      hcount     = vt[i].h;
      vcount     = vt[i].v;
      video_on   = vt[i].von;
      tick();
      chk($sformatf("vec%0d rom_char", i), rom_char, vt[i].ch);
      chk($sformatf("vec%0d rom_row", i), rom_row, vt[i].row);
      rom_pixels = vt[i].px;
      tick();
      chk($sformatf("vec%0d pix_on", i), pix_on, vt[i].pix);
    end

    hcount = 10'd0;
    vcount = 10'd0;
    pat    = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 6; i++) begin
      video_on = pat[i];
      tick();
      if (i > 0)
        chk($sformatf("video_on_d %0d", i), video_on_d, pat[i-1]);
    end

    pulse(0, 0, 1, 0);
    chk("clr left", score_left, 0);
    chk("clr right", score_right, 0);
    for (int i = 0; i < 9; i++) pulse(0, 1, 0, 0);
    chk("nine right", score_right, 9);
    chk("game_over set", game_over, 1);
    pulse(1, 1, 0, 0);
    chk("sat right", score_right, 9);
    chk("sat left", score_left, 0);

    pulse(0, 0, 1, 0);
    chk("game_over clr", game_over, 0);
    pulse(1, 1, 0, 0);
    chk("both left", score_left, 1);
    chk("both right", score_right, 1);
    pulse(1, 0, 1, 0);
    chk("clr prio left", score_left, 0);
    chk("clr prio right", score_right, 0);

    for (int i = 0; i < 8; i++) pulse(1, 0, 0, 0);
    pulse(1, 1, 0, 0);
    chk("both to win left", score_left, 9);
    chk("both to win right", score_right, 1);
    pulse(0, 0, 1, 0);

    rom_pixels = 8'hFF;
    hcount     = 10'd300;
    vcount     = 10'd20;
    video_on   = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst pix_on", pix_on, 0);
    chk("midrst vod", video_on_d, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("refill 1cyc pix_on", pix_on, 0);
    tick();
    chk("refill 2cyc pix_on", pix_on, 1);
    chk("refill rom_char", rom_char, 0);

`ifdef SCORE_FLASH_EN
    pulse(0, 0, 0, 1);
    pulse(1, 0, 0, 0);
    cnt = 60;
    for (int k = 1; k <= 62; k++) begin
      pulse(0, 0, 0, 1);
      if (cnt > 0) cnt--;
      pix_at(10'd300, 10'd20);
      chk($sformatf("flash L f%0d", k), pix_on,
          !((cnt != 0) && cnt[3]));
      pix_at(10'd360, 10'd20);
      chk($sformatf("flash R f%0d", k), pix_on, 1);
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
